// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//
// Generic pipeline stage register with a valid/ready handshake on both sides.
// It uses a two-entry skid buffer, so in_ready comes straight from registered
// state. The same block can serve as IF/ID, ID/EX, EX/MEM or MEM/WB, with the
// payload and control fields sized per instance.
//
// Features:
//   - flush turns the stage into a bubble. Any entry offered in the flush
//     cycle is dropped.
//   - Control bits read as zero whenever no valid entry is presented, so a
//     bubble can never write back.
//   - A saturating counter records the cycles in which downstream
//     backpressure held a valid entry.
//
// Parameters:
//   DATA_W  payload width (never masked)
//   CTRL_W  control width (forced to 0 on bubbles)
//   CNT_W   stall counter width
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active low
//   in_valid   upstream presents an entry
//   in_ready   stage can accept an entry (registered: low only when full)
//   in_data    upstream payload
//   in_ctrl    upstream control bits
//   out_valid  head entry is valid (registered)
//   out_ready  downstream accepts the head entry
//   out_data   head payload
//   out_ctrl   head control bits, 0 when out_valid is low
//   flush      discard all held entries
//   clr_cnt    clear the stall counter
//   occupancy  number of held entries (0..2)
//   stall_cnt  saturating count of backpressured cycles
// -----------------------------------------------------------------------------
module pipe_skid_stage #(
    parameter int DATA_W = 69,
    parameter int CTRL_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              clr_cnt,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int ENTRY_W = CTRL_W + DATA_W;

    // One state per number of held entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stateT;

    stateT              state;
    stateT              nextState;

    // Each register holds one {ctrl, data} entry.
    // mainReg is the head entry and drives the outputs.
    // skidReg holds the second entry, used only while FULL.
    logic [ENTRY_W-1:0] mainReg;
    logic [ENTRY_W-1:0] skidReg;
    logic [ENTRY_W-1:0] inEntry;

    logic               inFire;
    logic               outFire;
    logic               loadMainFromIn;
    logic               loadMainFromSkid;
    logic               loadSkidFromIn;

    logic [CNT_W-1:0]   stallCnt;

    assign inEntry = {in_ctrl, in_data};

    // Both handshake outputs decode only the registered state. Neither
    // in_valid nor out_ready can reach them combinationally.
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);

    assign inFire  = in_valid  & in_ready;
    assign outFire = out_valid & out_ready;

    assign out_data  = mainReg[DATA_W-1:0];
    assign out_ctrl  = out_valid ? mainReg[ENTRY_W-1:DATA_W] : '0;
    assign stall_cnt = stallCnt;

    // -------------------------------------------------------------------------
    // Next-state and register-load decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        nextState        = state;
        loadMainFromIn   = 1'b0;
        loadMainFromSkid = 1'b0;
        loadSkidFromIn   = 1'b0;

        if (flush) begin
            // Flush empties the stage and drops any entry accepted this
            // cycle. The data registers keep their contents; the bubble is
            // made visible through out_valid, which also masks out_ctrl.
            nextState = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (inFire) begin
                        loadMainFromIn = 1'b1;
                        nextState      = ONE;
                    end
                end

                ONE: begin
                    if (inFire && outFire) begin
                        // Pass-through: the head leaves as the new entry
                        // replaces it, giving one entry per cycle.
                        loadMainFromIn = 1'b1;
                    end else if (inFire) begin
                        loadSkidFromIn = 1'b1;
                        nextState      = FULL;
                    end else if (outFire) begin
                        nextState = EMPTY;
                    end
                end

                FULL: begin
                    // in_ready is low here, so no new entry can arrive.
                    if (outFire) begin
                        loadMainFromSkid = 1'b1;
                        nextState        = ONE;
                    end
                end

                default: begin
                    nextState = EMPTY;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State and data registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register here samples the values from before the edge.
        if (!rst) begin
            // NOTE: both entry registers are reset as well as the state, so
            // out_data reads zero after reset instead of stale payload.
            state   <= EMPTY;
            mainReg <= '0;
            skidReg <= '0;
        end else begin
            state <= nextState;
            if (loadMainFromIn) begin
                mainReg <= inEntry;
            end else if (loadMainFromSkid) begin
                mainReg <= skidReg;
            end
            if (loadSkidFromIn) begin
                skidReg <= inEntry;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Backpressure counter: counts cycles in which a valid head is refused.
    // A clear wins over an increment in the same cycle. Flush does not affect
    // the count.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            stallCnt <= '0;
        end else if (clr_cnt) begin
            stallCnt <= '0;
        end else if (out_valid && !out_ready && (stallCnt != '1)) begin
            stallCnt <= stallCnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Occupancy decode
    // -------------------------------------------------------------------------
    always_comb begin
        occupancy = 2'd0;
        unique case (state)
            EMPTY:   occupancy = 2'd0;
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule
